// File: rtl/regfile_pkg.sv
// Shared register-file geometry and types for the writeback path.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from last_grant+1, pointer moves on advance.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [IDX_W-1:0] grant_idx;
    logic             found;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        grant     = '0;
        grant_idx = last_grant_q;
        found     = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found && req[(int'(last_grant_q) + k) % N]) begin
                grant[(int'(last_grant_q) + k) % N] = 1'b1;
                grant_idx = IDX_W'((int'(last_grant_q) + k) % N);
                found     = 1'b1;
            end
        end
        last_grant_d = advance ? grant_idx : last_grant_q;
    end

    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= IDX_W'(N - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among writeback requesters and tracks
// pending destinations with one busy bit per architectural register.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    input  logic                             claim_valid,
    input  logic [ADDR_WIDTH-1:0]            claim_addr,
    output logic                             claim_ready,
    output logic [NUM_REGS-1:0]              reg_busy,
    output logic                             RegWrite,
    output logic [ADDR_WIDTH-1:0]            WriteRegister,
    output logic [DATA_WIDTH-1:0]            WriteData
);

    logic [NUM_REQ-1:0]    grant;
    logic                  handshake;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  reg_write_q, reg_write_d;
    logic [ADDR_WIDTH-1:0] write_register_q, write_register_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  clear_hit;
    logic                  claim_fire;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (CLK),
        .rst     (RESET),
        .req     (req_valid),
        .advance (handshake),
        .grant   (grant)
    );

    assign req_ready = RESET ? '0 : grant;
    assign handshake = |req_ready;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A write to x0 completes its handshake but never reaches the register file.
    always_comb begin
        reg_write_d      = handshake && (sel_addr != '0);
        write_register_d = handshake ? sel_addr : write_register_q;
        write_data_d     = handshake ? sel_data : write_data_q;
    end

    assign clear_hit   = reg_write_q && (write_register_q == claim_addr);
    assign claim_ready = !RESET && (!busy_q[claim_addr] || clear_hit || (claim_addr == '0));
    assign claim_fire  = claim_valid && claim_ready;

    // Clear is applied before set so a same-edge re-claim keeps the bit high.
    always_comb begin
        busy_d = busy_q;
        if (reg_write_q) begin
            busy_d[write_register_q] = 1'b0;
        end
        if (claim_fire) begin
            busy_d[claim_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            reg_write_q      <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
            busy_q           <= '0;
        end else begin
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
            busy_q           <= busy_d;
        end
    end

    assign RegWrite      = reg_write_q;
    assign WriteRegister = write_register_q;
    assign WriteData     = write_data_q;
    assign reg_busy      = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural register file on the write port.
module tb_regfile_wb_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic        claim_valid;
    logic [4:0]  claim_addr;
    logic        claim_ready;
    logic [31:0] reg_busy;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;

    logic [31:0] rf [32];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cnt0, cnt1;
    logic [1:0]  exp_grant;

    regfile_wb_arbiter #(.NUM_REQ(2), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .claim_valid   (claim_valid),
        .claim_addr    (claim_addr),
        .claim_ready   (claim_ready),
        .reg_busy      (reg_busy),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RegWrite) rf[WriteRegister] <= WriteData;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[i*5 +: 5]   = a;
        req_data[i*32 +: 32] = d;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        RESET       = 1'b1;
        req_valid   = 2'b11;
        req_addr    = '0;
        req_data    = '0;
        claim_valid = 1'b0;
        claim_addr  = 5'd0;
        set_req(0, 5'd1, 32'h11111111);
        set_req(1, 5'd2, 32'h22222222);

        // Reset held for two edges; handshakes are suppressed while it is high.
        step();
        step();
        check("rst_req_ready", {30'b0, req_ready}, 32'h0);
        check("rst_claim_ready", {31'b0, claim_ready}, 32'h0);
        check("rst_regwrite", {31'b0, RegWrite}, 32'h0);
        check("rst_wreg", {27'b0, WriteRegister}, 32'h0);
        check("rst_wdata", WriteData, 32'h0);
        check("rst_busy", reg_busy, 32'h0);
        check("rst_rf_x1", rf[1], 32'h0);

        // Contention straight out of reset: requester 0 first.
        RESET = 1'b0;
        #1;
        check("cont_grant0", {30'b0, req_ready}, 32'h1);
        step();
        req_valid = 2'b10;
        #1;
        check("cont_grant1", {30'b0, req_ready}, 32'h2);
        check("cont_we0", {31'b0, RegWrite}, 32'h1);
        check("cont_wreg0", {27'b0, WriteRegister}, 32'd1);
        check("cont_wdata0", WriteData, 32'h11111111);
        step();
        req_valid = 2'b00;
        #1;
        check("cont_idle_ready", {30'b0, req_ready}, 32'h0);
        check("cont_we1", {31'b0, RegWrite}, 32'h1);
        check("cont_wreg1", {27'b0, WriteRegister}, 32'd2);
        check("cont_wdata1", WriteData, 32'h22222222);
        check("cont_rf_x1", rf[1], 32'h11111111);
        step();
        check("idle_we", {31'b0, RegWrite}, 32'h0);
        check("idle_wreg_hold", {27'b0, WriteRegister}, 32'd2);
        check("idle_wdata_hold", WriteData, 32'h22222222);
        check("cont_rf_x2", rf[2], 32'h22222222);

        // Fairness: both continuously valid for 8 cycles.
        set_req(0, 5'd4, 32'hA0A0A0A0);
        set_req(1, 5'd5, 32'hB0B0B0B0);
        req_valid = 2'b11;
        cnt0 = 0;
        cnt1 = 0;
        exp_grant = 2'b01;
        #1;
        for (int c = 0; c < 8; c++) begin
            check("rr_grant", {30'b0, req_ready}, {30'b0, exp_grant});
            if (req_ready[0]) cnt0++;
            if (req_ready[1]) cnt1++;
            exp_grant = ~exp_grant;
            step();
        end
        req_valid = 2'b00;
        check("rr_count0", cnt0, 32'd4);
        check("rr_count1", cnt1, 32'd4);

        // x0 write: accepted but squashed.
        set_req(0, 5'd0, 32'h12345678);
        req_valid = 2'b01;
        #1;
        check("x0_ready", {30'b0, req_ready}, 32'h1);
        step();
        req_valid = 2'b00;
        check("x0_we", {31'b0, RegWrite}, 32'h0);
        check("x0_wreg", {27'b0, WriteRegister}, 32'd0);
        step();
        check("x0_rf", rf[0], 32'h0);

        // x0 claim is always accepted and never marks busy.
        claim_valid = 1'b1;
        claim_addr  = 5'd0;
        #1;
        check("x0_claim_ready", {31'b0, claim_ready}, 32'h1);
        step();
        check("x0_busy", {31'b0, reg_busy[0]}, 32'h0);

        // Claim x3, second claim refused, then write clears it.
        claim_addr = 5'd3;
        #1;
        check("claim3_ready", {31'b0, claim_ready}, 32'h1);
        step();
        check("claim3_busy", {31'b0, reg_busy[3]}, 32'h1);
        check("claim3_again_ready", {31'b0, claim_ready}, 32'h0);
        claim_valid = 1'b0;
        set_req(0, 5'd3, 32'h33333333);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        check("w3_we", {31'b0, RegWrite}, 32'h1);
        check("w3_busy_still", {31'b0, reg_busy[3]}, 32'h1);
        check("w3_clear_hit_ready", {31'b0, claim_ready}, 32'h1);
        step();
        check("w3_busy_cleared", {31'b0, reg_busy[3]}, 32'h0);
        check("w3_rf", rf[3], 32'h33333333);

        // Re-claim x3 on the very edge its next write commits.
        claim_valid = 1'b1;
        step();
        claim_valid = 1'b0;
        check("reclaim_busy", {31'b0, reg_busy[3]}, 32'h1);
        set_req(0, 5'd3, 32'h44444444);
        req_valid = 2'b01;
        step();
        req_valid   = 2'b00;
        claim_valid = 1'b1;
        #1;
        check("same_edge_claim_ready", {31'b0, claim_ready}, 32'h1);
        step();
        claim_valid = 1'b0;
        check("same_edge_busy", {31'b0, reg_busy[3]}, 32'h1);
        check("same_edge_rf", rf[3], 32'h44444444);

        // Reset mid-stream with a write in flight and registers busy.
        claim_valid = 1'b1;
        claim_addr  = 5'd5;
        step();
        claim_valid = 1'b0;
        check("claim5_busy", reg_busy, 32'h00000028);
        set_req(1, 5'd7, 32'h77777777);
        req_valid = 2'b10;
        #1;
        check("mid_grant1", {30'b0, req_ready}, 32'h2);
        step();
        RESET = 1'b1;
        #1;
        check("mid_rst_ready", {30'b0, req_ready}, 32'h0);
        step();
        check("mid_rst_we", {31'b0, RegWrite}, 32'h0);
        check("mid_rst_wreg", {27'b0, WriteRegister}, 32'h0);
        check("mid_rst_wdata", WriteData, 32'h0);
        check("mid_rst_busy", reg_busy, 32'h0);
        RESET = 1'b0;
        req_valid = 2'b11;
        #1;
        check("post_rst_grant0", {30'b0, req_ready}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
